// File: rtl/spi_master_cfg_if.sv
// Request and SPI pin bundle for spi_master_cfg.
// The master modport is the controller side; the slave modport is the requester and slave side.
interface spi_master_cfg_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_SS     = 4,
   parameter int DIV_WIDTH  = 8,
   parameter int SEL_WIDTH  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
);
   logic                  start;
   logic [DATA_WIDTH-1:0] data_in_master;
   logic [SEL_WIDTH-1:0]  ss_sel;
   logic                  cpol;
   logic                  cpha;
   logic                  lsb_first;
   logic [DIV_WIDTH-1:0]  clk_div;
   logic                  miso;
   logic                  sclk_m;
   logic                  mosi;
   logic [NUM_SS-1:0]     ss;
   logic                  busy;
   logic                  finish;
   logic [DATA_WIDTH-1:0] data_out_master;

   modport master (
      input  start, data_in_master, ss_sel, cpol, cpha, lsb_first, clk_div, miso,
      output sclk_m, mosi, ss, busy, finish, data_out_master
   );

   modport slave (
      output start, data_in_master, ss_sel, cpol, cpha, lsb_first, clk_div, miso,
      input  sclk_m, mosi, ss, busy, finish, data_out_master
   );
endinterface

// File: rtl/spi_master_cfg.sv
// SPI master with run-time CPOL/CPHA, SCLK divider and bit order; one transfer per accept.
module spi_master_cfg #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_SS     = 4,
   parameter int DIV_WIDTH  = 8,
   parameter int SEL_WIDTH  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input logic              clk_m,
   input logic              rst_n,
   spi_master_cfg_if.master bus_io
);
   localparam int EW = $clog2(2 * DATA_WIDTH);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_e;

   state_e                state_q, state_d;
   logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d;
   logic [EW-1:0]         edge_q, edge_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
   logic [NUM_SS-1:0]     ss_q, ss_d;
   logic cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
   logic sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d, fin_q, fin_d;
   logic accept, boundary, leading, last_edge, sample, drive;

   function automatic logic cur_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
      return lsb ? w[0] : w[DATA_WIDTH-1];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                        input logic lsb);
      return lsb ? {1'b0, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], 1'b0};
   endfunction

   assign accept    = bus_io.start && !busy_q && (int'(bus_io.ss_sel) < NUM_SS);
   assign boundary  = (cnt_q == '0);
   assign leading   = ~edge_q[0];
   assign last_edge = (edge_q == EW'(2 * DATA_WIDTH - 1));
   assign sample    = (edge_q[0] == cpha_q);
   // cpha=0 pre-loads bit 0 at accept, so trailing edges carry the rest (none after the last bit).
   assign drive     = cpha_q ? leading : (!leading && !last_edge);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      edge_d  = edge_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      ss_d    = ss_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      lsb_d   = lsb_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      busy_d  = busy_q;
      fin_d   = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (state_q == DONE) state_d = IDLE;
            if (accept) begin
               state_d = SETUP;
               cnt_d   = bus_io.clk_div;
               div_d   = bus_io.clk_div;
               edge_d  = '0;
               cpol_d  = bus_io.cpol;
               cpha_d  = bus_io.cpha;
               lsb_d   = bus_io.lsb_first;
               sclk_d  = bus_io.cpol;
               mosi_d  = cur_bit(bus_io.data_in_master, bus_io.lsb_first);
               tx_d    = bus_io.cpha ? bus_io.data_in_master
                                     : shift_out(bus_io.data_in_master, bus_io.lsb_first);
               rx_d    = '0;
               ss_d    = ~(NUM_SS'(1) << bus_io.ss_sel);
               busy_d  = 1'b1;
            end
         end
         SETUP, XFER: begin
            if (boundary) begin
               cnt_d   = div_q;
               sclk_d  = ~sclk_q;
               edge_d  = edge_q + EW'(1);
               state_d = last_edge ? HOLD : XFER;
               if (sample)
                  rx_d = lsb_q ? {bus_io.miso, rx_q[DATA_WIDTH-1:1]}
                               : {rx_q[DATA_WIDTH-2:0], bus_io.miso};
               if (drive) begin
                  mosi_d = cur_bit(tx_q, lsb_q);
                  tx_d   = shift_out(tx_q, lsb_q);
               end
            end else begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end
         end
         HOLD: begin
            sclk_d = cpol_q;
            if (boundary) begin
               state_d = DONE;
               ss_d    = '1;
               fin_d   = 1'b1;
               dout_d  = rx_q;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_m or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         edge_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         dout_q  <= '0;
         ss_q    <= '1;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         lsb_q   <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         edge_q  <= edge_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         ss_q    <= ss_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         lsb_q   <= lsb_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         fin_q   <= fin_d;
      end
   end

   assign bus_io.sclk_m          = sclk_q;
   assign bus_io.mosi            = mosi_q;
   assign bus_io.ss              = ss_q;
   assign bus_io.busy            = busy_q;
   assign bus_io.finish          = fin_q;
   assign bus_io.data_out_master = dout_q;
endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg (NUM_SS=3) with a behavioural SPI slave on the bus.
module tb_spi_master_cfg;
   localparam int DW  = 8;
   localparam int NSS = 3;
   localparam int DVW = 8;

   logic clk_m = 1'b0;
   logic rst_n = 1'b1;
   int   n_pass  = 0;
   int   n_chk   = 0;
   int   fin_cnt = 0;

   spi_master_cfg_if #(.DATA_WIDTH(DW), .NUM_SS(NSS), .DIV_WIDTH(DVW)) bus ();

   spi_master_cfg #(.DATA_WIDTH(DW), .NUM_SS(NSS), .DIV_WIDTH(DVW)) dut (
      .clk_m (clk_m),
      .rst_n (rst_n),
      .bus_io(bus)
   );

   always #5 clk_m = ~clk_m;

   always @(posedge clk_m) if (bus.finish === 1'b1) fin_cnt++;

   // Slave model: mode set by s_cpol/s_cpha, bit order by s_lsb; returns s_tx, collects s_rx.
   logic          s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0, ss_prev = 1'b1;
   logic [DW-1:0] s_tx = '0, s_rx = '0;
   int            s_idx = 0, s_tog = 0;
   time           s_t0 = 0;
   logic          ss_all;
   assign ss_all = &bus.ss;

   function automatic logic sbit(input int i);
      return s_lsb ? s_tx[i] : s_tx[DW-1-i];
   endfunction

   // An SCLK idle-level change that coincides with select is not a clock edge for the slave.
   always @(bus.sclk_m or ss_all) begin
      if (ss_prev && !ss_all) begin
         s_idx = 0;
         s_rx  = '0;
         s_tog = 0;
         s_t0  = $time;
         if (!s_cpha) bus.miso = sbit(0);
      end else if (!ss_all && $time != s_t0) begin
         s_tog++;
         if ((bus.sclk_m != s_cpol) ^ s_cpha) begin
            s_rx = s_lsb ? {bus.mosi, s_rx[DW-1:1]} : {s_rx[DW-2:0], bus.mosi};
            if (s_cpha) s_idx++;
         end else begin
            if (!s_cpha) s_idx++;
            if (s_idx < DW) bus.miso = sbit(s_idx);
         end
      end
      ss_prev = ss_all;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_m);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic setup(input logic cpol, input logic cpha, input logic lsb, input int div,
                        input int sel, input logic [DW-1:0] data, input logic [DW-1:0] stx);
      bus.cpol = cpol; bus.cpha = cpha; bus.lsb_first = lsb; bus.clk_div = DVW'(div);
      bus.ss_sel = 2'(sel); bus.data_in_master = data;
      s_cpol = cpol; s_cpha = cpha; s_lsb = lsb; s_tx = stx;
   endtask

   initial begin
      bus.start = 1'b0; bus.data_in_master = '0; bus.ss_sel = '0; bus.cpol = 1'b0;
      bus.cpha = 1'b0; bus.lsb_first = 1'b0; bus.clk_div = '0;
      #2 rst_n = 1'b0;
      tick(2);
      chk("rst_sclk", bus.sclk_m, 0);
      chk("rst_mosi", bus.mosi, 0);
      chk("rst_ss", bus.ss, 3'b111);
      chk("rst_busy", bus.busy, 0);
      chk("rst_finish", bus.finish, 0);
      chk("rst_dout", bus.data_out_master, 0);
      rst_n = 1'b1;
      tick(1);

      // Mode 0, H=2, ss 2, A5 out, 3C back MSB-first
      setup(0, 0, 0, 1, 2, 8'hA5, 8'h3C);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      chk("m0_ss", bus.ss, 3'b011);
      chk("m0_busy", bus.busy, 1);
      chk("m0_mosi_first", bus.mosi, 1);
      tick(1);
      chk("m0_sclk_e1", bus.sclk_m, 0);
      tick(1);
      chk("m0_sclk_rise_e2", bus.sclk_m, 1);
      tick(31);
      chk("m0_fin_e33", bus.finish, 0);
      chk("m0_ss_e33", bus.ss, 3'b011);
      tick(1);
      chk("m0_fin_e34", bus.finish, 1);
      chk("m0_dout", bus.data_out_master, 8'h3C);
      chk("m0_ss_done", bus.ss, 3'b111);
      chk("m0_busy_done", bus.busy, 0);
      chk("m0_slave_rx", s_rx, 8'hA5);
      chk("m0_toggles", s_tog, 16);
      tick(1);
      chk("m0_fin_pulse", bus.finish, 0);
      chk("m0_dout_hold", bus.data_out_master, 8'h3C);

      // Mode 3, LSB-first, H=1, ss 0, 81 out, 0F back
      setup(1, 1, 1, 0, 0, 8'h81, 8'h0F);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      chk("m3_sclk_idle", bus.sclk_m, 1);
      chk("m3_ss", bus.ss, 3'b110);
      chk("m3_mosi_first", bus.mosi, 1);
      tick(1);
      chk("m3_sclk_fall_e1", bus.sclk_m, 0);
      tick(15);
      chk("m3_fin_e16", bus.finish, 0);
      tick(1);
      chk("m3_fin_e17", bus.finish, 1);
      chk("m3_dout", bus.data_out_master, 8'h0F);
      chk("m3_slave_rx", s_rx, 8'h81);

      // Mode 1, H=4, ss 1, 5A out, C3 back; accepted in the DONE cycle, inputs scrambled after
      setup(0, 1, 0, 3, 1, 8'h5A, 8'hC3);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      chk("m1_ss", bus.ss, 3'b101);
      chk("m1_mosi_first", bus.mosi, 0);
      bus.data_in_master = 8'hFF; bus.clk_div = '0; bus.cpha = 1'b0; bus.cpol = 1'b1;
      bus.lsb_first = 1'b1; bus.ss_sel = '0;
      tick(67);
      chk("m1_fin_e67", bus.finish, 0);
      tick(1);
      chk("m1_fin_e68", bus.finish, 1);
      chk("m1_dout", bus.data_out_master, 8'hC3);
      chk("m1_slave_rx", s_rx, 8'h5A);
      chk("m1_toggles", s_tog, 16);

      // Back-to-back with start held high, H=1: 11 then 22
      setup(0, 0, 0, 0, 2, 8'h11, 8'h96);
      bus.start = 1'b1;
      tick(1);
      bus.data_in_master = 8'h22;
      chk("b2b_busy", bus.busy, 1);
      tick(16);
      chk("b2b_fin1_early", bus.finish, 0);
      tick(1);
      chk("b2b_fin1", bus.finish, 1);
      chk("b2b_ss_gap", bus.ss, 3'b111);
      chk("b2b_slave_rx1", s_rx, 8'h11);
      tick(1);
      chk("b2b_fin1_pulse", bus.finish, 0);
      chk("b2b_ss_relow", bus.ss, 3'b011);
      chk("b2b_mosi2_first", bus.mosi, 0);
      tick(16);
      chk("b2b_fin2_early", bus.finish, 0);
      tick(1);
      chk("b2b_fin2", bus.finish, 1);
      chk("b2b_slave_rx2", s_rx, 8'h22);
      chk("b2b_dout", bus.data_out_master, 8'h96);
      bus.start = 1'b0;
      tick(1);
      chk("b2b_idle_busy", bus.busy, 0);
      chk("b2b_idle_ss", bus.ss, 3'b111);

      // Asynchronous reset in the middle of bit 4
      setup(0, 0, 0, 1, 2, 8'hA5, 8'h3C);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      tick(18);
      chk("mid_sclk_before", bus.sclk_m, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ss", bus.ss, 3'b111);
      chk("mid_rst_sclk", bus.sclk_m, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_dout", bus.data_out_master, 0);
      tick(1);
      rst_n = 1'b1;
      tick(1);

      // Mode 2 after reset, H=3, ss 1, 3C out, E7 back
      setup(1, 0, 0, 2, 1, 8'h3C, 8'hE7);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      chk("m2_sclk_idle", bus.sclk_m, 1);
      chk("m2_ss", bus.ss, 3'b101);
      tick(50);
      chk("m2_fin_e50", bus.finish, 0);
      tick(1);
      chk("m2_fin_e51", bus.finish, 1);
      chk("m2_dout", bus.data_out_master, 8'hE7);
      chk("m2_slave_rx", s_rx, 8'h3C);

      // Out-of-range select is ignored
      tick(1);
      bus.ss_sel = 2'd3;
      bus.start = 1'b1;
      tick(1);
      chk("bad_sel_busy", bus.busy, 0);
      chk("bad_sel_ss", bus.ss, 3'b111);
      tick(20);
      chk("bad_sel_busy_late", bus.busy, 0);
      chk("finish_count", fin_cnt, 6);
      bus.start = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
